// File: rtl/seed_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seed_pkg
// Brief    : Shared constants and state encoding for the SEED round sequencer.
// Revision : 1.0
// ============================================================================
package seed_pkg;

  localparam int SEED_ROUNDS = 16;
  localparam int SEED_RW     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

endpackage
`default_nettype wire

// File: rtl/seed_key_addr.sv
`default_nettype none
// ============================================================================
// Module   : seed_key_addr
// Brief    : Subkey word address from round, phase and latched direction.
// Revision : 1.0
// ============================================================================
module seed_key_addr
  import seed_pkg::*;
#(
  parameter int NUM_ROUNDS = SEED_ROUNDS,
  parameter int RW         = SEED_RW
) (
  input  logic [RW-1:0] round,
  input  logic          phase,
  input  logic          mode_latched,
  output logic [RW:0]   sk_index
);

  localparam logic [RW-1:0] c_last_round = RW'(NUM_ROUNDS - 1);

  logic [RW-1:0] w_key_round;

  // Decryption walks the key schedule backwards while the datapath round ascends.
  assign w_key_round = (mode_latched == MODE_DEC) ? (c_last_round - round) : round;
  assign sk_index    = {w_key_round, phase};

endmodule
`default_nettype wire

// File: rtl/seed_round_seq.sv
`default_nettype none
// ============================================================================
// Module   : seed_round_seq
// Brief    : SEED round sequencer: block handshake, round/phase counting,
//            subkey addressing and done/key_err reporting.
// Revision : 1.0
// ============================================================================
module seed_round_seq
  import seed_pkg::*;
#(
  parameter int NUM_ROUNDS = SEED_ROUNDS,
  parameter int RW         = SEED_RW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          key_ready,
  input  logic          mode,
  input  logic          blk_valid,
  output logic          blk_ready,
  input  logic          abort,
  output logic          clk_en,
  output logic          phase,
  output logic [RW-1:0] round,
  output logic [RW:0]   sk_index,
  output logic          last_round,
  output logic          busy,
  output logic          done,
  output logic          key_err
);

  localparam logic [RW-1:0] c_last    = RW'(NUM_ROUNDS - 1);
  localparam logic [RW-1:0] c_last_m1 = RW'(NUM_ROUNDS - 2);

  seq_state_e    r_state;
  logic          r_mode;
  logic          r_phase;
  logic [RW-1:0] r_round;
  logic          r_last;
  logic          r_busy;
  logic          r_done;
  logic          r_key_err;
  logic [RW:0]   w_sk_raw;
  logic          w_running;

  assign w_running = (r_state == RUN);

  seed_key_addr #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .RW         (RW)
  ) u_key_addr (
    .round        (r_round),
    .phase        (r_phase),
    .mode_latched (r_mode),
    .sk_index     (w_sk_raw)
  );

  assign blk_ready  = (r_state == IDLE) && key_ready;
  // Abort or a lost key schedule cancels the round advance of that cycle.
  assign clk_en     = w_running && r_phase && !abort && key_ready;
  assign sk_index   = w_running ? w_sk_raw : '0;
  assign phase      = r_phase;
  assign round      = r_round;
  assign last_round = r_last;
  assign busy       = r_busy;
  assign done       = r_done;
  assign key_err    = r_key_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_mode    <= MODE_ENC;
      r_phase   <= 1'b0;
      r_round   <= '0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_key_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_key_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (blk_valid && key_ready) begin
            r_mode  <= mode;
            r_round <= '0;
            r_phase <= 1'b0;
            r_last  <= (c_last == '0);
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!key_ready || abort) begin
            r_key_err <= !key_ready;
            r_round   <= '0;
            r_phase   <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else if (!r_phase) begin
            r_phase <= 1'b1;
          end else if (r_round == c_last) begin
            r_round <= '0;
            r_phase <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_round <= r_round + RW'(1);
            r_phase <= 1'b0;
            r_last  <= (r_round == c_last_m1);
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seed_round_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_seed_round_seq
// Brief    : Randomized scoreboard bench for seed_round_seq.
// Revision : 1.0
// ============================================================================
module tb_seed_round_seq;

  localparam int N = 16;

  typedef struct packed {
    logic       clk_en;
    logic       phase;
    logic [3:0] round;
    logic [4:0] sk;
    logic       last;
    logic       busy;
    logic       done;
    logic       key_err;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       key_ready;
  logic       mode;
  logic       blk_valid;
  logic       blk_ready;
  logic       abort;
  logic       clk_en;
  logic       phase;
  logic [3:0] round;
  logic [4:0] sk_index;
  logic       last_round;
  logic       busy;
  logic       done;
  logic       key_err;

  int checks   = 0;
  int failures = 0;

  rec_t sb[$];
  bit   sb_idle[$];
  rec_t mon_e;
  bit   mon_idle;

  seed_round_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_ready  (key_ready),
    .mode       (mode),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .abort      (abort),
    .clk_en     (clk_en),
    .phase      (phase),
    .round      (round),
    .sk_index   (sk_index),
    .last_round (last_round),
    .busy       (busy),
    .done       (done),
    .key_err    (key_err)
  );

  always #5 clk = ~clk;

  function automatic rec_t cur_rec();
    rec_t a;
    a.clk_en  = clk_en;
    a.phase   = phase;
    a.round   = round;
    a.sk      = sk_index;
    a.last    = last_round;
    a.busy    = busy;
    a.done    = done;
    a.key_err = key_err;
    return a;
  endfunction

  // Cycle c (1..2N) of a run: round (c-1)/2, phase (c-1)%2.
  function automatic rec_t run_rec(bit m, int c, bit masked);
    int   r  = (c - 1) / 2;
    int   p  = (c - 1) % 2;
    int   kr = m ? (N - 1 - r) : r;
    rec_t x  = '0;
    x.clk_en = (p == 1) && !masked;
    x.phase  = p[0];
    x.round  = 4'(r);
    x.sk     = 5'(kr * 2 + p);
    x.last   = (r == N - 1);
    x.busy   = 1'b1;
    return x;
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(rec_t x, bit idle);
    sb.push_back(x);
    sb_idle.push_back(idle);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every DUT-visible activity cycle consumes one expected record.
  always @(negedge clk) begin
    if (reset_n) begin
      if (busy || done || key_err) begin
        if (sb.size() == 0) begin
          check("unexpected_activity", 16'(cur_rec()), 16'h0);
        end else begin
          mon_e    = sb.pop_front();
          mon_idle = sb_idle.pop_front();
          check("outputs", 16'(cur_rec()), 16'(mon_e));
          check("blk_ready_busy", 16'(blk_ready), 16'(mon_idle && key_ready));
        end
      end else begin
        check("idle_outputs", 16'(cur_rec()), 16'h0);
        check("idle_blk_ready", 16'(blk_ready), 16'(key_ready));
      end
    end
  end

  // kind: 0 normal, 1 abort at cycle k, 2 key_ready drop at cycle k for dlen
  // cycles, 3 async reset at cycle k. mreq < 0 picks a random mode.
  task automatic run_block(int kind, int k, int dlen, bit hold, int mreq);
    bit m;
    int n;
    rec_t d;
    m = (mreq < 0) ? bit'($urandom_range(0, 1)) : bit'(mreq);
    d = '0;
    d.done = 1'b1;
    d.busy = 1'b1;
    key_ready = 1'b1;
    blk_valid = 1'b1;
    mode      = m;
    abort     = 1'($urandom_range(0, 1));
    n = 0;
    case (kind)
      0: begin
        for (int c = 1; c <= 2 * N; c++) push(run_rec(m, c, 1'b0), 1'b0);
        push(d, 1'b0);
        n = 2 * N + 1;
      end
      1: begin
        for (int c = 1; c <= k; c++) begin
          if (c <= 2 * N) push(run_rec(m, c, c == k), 1'b0);
          else push(d, 1'b0);
        end
        n = k;
      end
      2: begin
        rec_t ke = '0;
        ke.key_err = 1'b1;
        for (int c = 1; c <= k; c++) push(run_rec(m, c, c == k), 1'b0);
        push(ke, 1'b1);
        n = k + dlen;
      end
      default: begin
        for (int c = 1; c < k; c++) push(run_rec(m, c, 1'b0), 1'b0);
        n = k - 1;
      end
    endcase
    step();
    for (int c = 1; c <= n; c++) begin
      blk_valid = hold;
      mode      = 1'($urandom_range(0, 1));
      abort     = (kind == 1 && c == k) || (kind == 2 && c == k && $urandom_range(0, 1) == 1);
      key_ready = !(kind == 2 && c >= k && c < k + dlen);
      step();
    end
    abort     = 1'b0;
    key_ready = 1'b1;
    blk_valid = hold;
    if (kind == 3) begin
      #2;
      reset_n = 1'b0;
      sb.delete();
      sb_idle.delete();
      #1;
      check("reset_outputs", 16'(cur_rec()), 16'h0);
      check("reset_blk_ready", 16'(blk_ready), 16'(key_ready));
      @(posedge clk);
      #2;
      reset_n = 1'b1;
      run_block(0, 0, 0, 1'b0, -1);
    end
  endtask

  task automatic idle_gap(int cycles);
    for (int i = 0; i < cycles; i++) begin
      blk_valid = 1'b0;
      abort     = 1'($urandom_range(0, 1));
      key_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    abort     = 1'b0;
    key_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int kind;
    bit hold;
    reset_n   = 1'b0;
    key_ready = 1'b1;
    mode      = 1'b0;
    blk_valid = 1'b0;
    abort     = 1'b0;
    #3;
    check("por_outputs", 16'(cur_rec()), 16'h0);
    check("por_blk_ready", 16'(blk_ready), 16'h1);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    step();

    run_block(0, 0, 0, 1'b0, 0);   // encrypt
    idle_gap(2);
    run_block(0, 0, 0, 1'b1, 1);   // decrypt, blk_valid held into next block
    run_block(0, 0, 0, 1'b0, -1);  // back-to-back accept
    idle_gap(1);
    run_block(1, 10, 0, 1'b0, -1); // abort at round 4 phase 1
    run_block(0, 0, 0, 1'b0, -1);
    idle_gap(1);
    run_block(2, 20, 3, 1'b0, -1); // key_ready lost
    idle_gap(1);
    run_block(3, 15, 0, 1'b0, -1); // async reset mid-block
    idle_gap(1);

    for (int b = 0; b < 30; b++) begin
      kind = $urandom_range(0, 5);
      if (kind > 3) kind = kind - 3;
      hold = (kind == 0) && ($urandom_range(0, 1) == 1);
      case (kind)
        0: run_block(0, 0, 0, hold, -1);
        1: run_block(1, $urandom_range(1, 2 * N + 1), 0, 1'b0, -1);
        2: run_block(2, $urandom_range(1, 2 * N), $urandom_range(1, 3), 1'b0, -1);
        default: run_block(3, $urandom_range(2, 30), 0, 1'b0, -1);
      endcase
      if (!hold) idle_gap($urandom_range(0, 3));
    end

    blk_valid = 1'b0;
    idle_gap(3);
    check("scoreboard_drained", 16'(sb.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seed_round_seq.md
Name: seed_round_seq

Overview:
Round sequencer for the SEED datapath, on the consumer side of the round-count interface. It accepts one 128-bit block request at a time through a valid/ready handshake and generates the per-round enable pulse. It drives the round index and the subkey index into the key store: ascending for encryption, descending for decryption. It sits between the block input interface and the round function/key store, and reports completion with a one-cycle done pulse.

Parameters:
NUM_ROUNDS, 16, number of SEED rounds; power of two, at least 2
RW, 4, round index width = log2(NUM_ROUNDS)

Ports:
clk  in  1  internal 100MHz clock
reset_n  in  1  asynchronous, active-low reset
key_ready  in  1  high when the key schedule has finished creating all subkeys
mode  in  1  0 = encrypt (ascending keys), 1 = decrypt (descending keys); sampled on accept
blk_valid  in  1  block request valid
blk_ready  out  1  sequencer can accept a block
abort  in  1  synchronous cancel of the running block
clk_en  out  1  round-advance pulse, one cycle in every two while running
phase  out  1  0 = first cycle of round, 1 = second cycle (subkey half select)
round  out  RW  datapath round number, always ascending 0..NUM_ROUNDS-1
sk_index  out  RW+1  subkey word address = {key_round, phase}
last_round  out  1  high during both cycles of round NUM_ROUNDS-1
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse at the end of a complete block
key_err  out  1  one-cycle pulse when key_ready drops during RUN

Behaviour:
- States: IDLE, RUN, DONE. Reset (reset_n low, asynchronous): state=IDLE. All outputs are 0, except that blk_ready follows key_ready combinationally from IDLE.
- blk_ready = (state==IDLE) && key_ready. Accept = blk_valid && blk_ready. On accept: latch mode, round<=0, phase<=0, state<=RUN.
- RUN: phase toggles every cycle, starting at 0. clk_en = (state==RUN) && phase==1. round increments on the clk_en cycle and wraps via the RW width only at exit.
- key_round = mode_latched ? (NUM_ROUNDS-1-round) : round. sk_index = {key_round, phase}, combinational from registers. It is 0 when not in RUN.
- Exit from RUN: in the cycle with phase==1 and round==NUM_ROUNDS-1, go to DONE and clear round/phase to 0.
- DONE lasts exactly one cycle: done=1, busy=1, blk_ready=0. It then goes to IDLE. A new block cannot be accepted in DONE.
- Latency: accept at edge T. RUN covers cycles T+1..T+2*NUM_ROUNDS (32 cycles), with 16 clk_en pulses. done is high in cycle T+33. The earliest next accept is in cycle T+34.
- abort in RUN or DONE: go to IDLE next edge and clear round/phase. No done pulse and no clk_en in the abort cycle (abort masks clk_en). abort in IDLE has no effect. It does not block an accept in the same cycle.
- key_ready low while in RUN: go to IDLE next edge with key_err=1 for one cycle and no done pulse. clk_en is masked in that cycle. abort and key_ready-low in the same cycle: key_err takes priority.
- mode changes after accept have no effect until the next accept.
- reset_n asserted mid-block: immediate return to IDLE with all outputs cleared. No done or key_err pulse follows.
- Output timing: all outputs except blk_ready, clk_en and sk_index are registered.

Decomposition:
- Shared package seed_pkg holds: SEED_ROUNDS=16, SEED_RW=4, the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2), and MODE_ENC/MODE_DEC.
- One natural sub-module: seed_key_addr. It is combinational: inputs round, phase and mode_latched; output sk_index. It is reused by the key-store read port.
- The state machine and counters stay in seed_round_seq.

Test Plan:
- Encrypt run: key_ready=1, mode=0, blk_valid pulse at T. Expected:
  - clk_en high at T+2, T+4, ..., T+32 (16 pulses).
  - sk_index sequence 0,1,2,...,31.
  - last_round high in T+31..T+32.
  - done only in T+33; blk_ready back high at T+34.
- Decrypt run: mode=1 at accept, toggled to 0 at T+5. Expected sk_index 30,31,28,29,...,0,1 (descending key_round 15..0, phase order kept); round output still ascends 0..15.
- Back-to-back: blk_valid held high continuously. Expected accepts at T and T+34, blk_ready=0 throughout T+1..T+33, and exactly 2 done pulses.
- Abort at T+10 (round 4, phase 1). Expected:
  - no clk_en at T+10; IDLE at T+11.
  - no done pulse.
  - round=0 and sk_index=0 from T+11.
  - next accept works normally.
- key_ready dropped at T+20. Expected key_err=1 in T+21, state IDLE, no done pulse, and blk_ready stays 0 until key_ready returns.
- Async reset_n pulse low mid-cycle at T+15. Expected all outputs 0 immediately without waiting for a clk edge; after release, blk_valid=1 with key_ready=1 is accepted on the next edge.
